rs_ff_bank: RTL

Parametrised multi-channel clocked RS register bank, the successor to the single-bit RS flip-flop. Each channel holds one state bit driven by synchronous set/reset commands with a selectable conflict policy (reset-dominant, set-dominant, hold, or JK-style toggle) and an optional per-channel input qualification filter. The bank also produces per-channel change pulses and a sticky conflict flag. It sits between raw control/status strobes and the control logic that consumes latched flags.

---
 rtl/rs_ff_bank_if.sv | 22 ++
 rtl/rs_ff_bank.sv | 99 +++++++++
 2 files changed

// File: rtl/rs_ff_bank_if.sv
// rtl/rs_ff_bank_if.sv - command and status bundle for the RS register bank
interface rs_ff_bank_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] s;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] changed;
  logic             conflict;

  modport master (
    output r, s, err_clr,
    input  q, qb, changed, conflict
  );

  modport slave (
    input  r, s, err_clr,
    output q, qb, changed, conflict
  );
endinterface

// File: rtl/rs_ff_bank.sv
// rtl/rs_ff_bank.sv - multi-channel clocked RS register bank with command filter and conflict policy
module rs_ff_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter int               FILTER        = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input logic         clk,
  input logic         rst,
  rs_ff_bank_if.slave bus
);
  // Counter just wide enough to reach FILTER; a filter of 0 still keeps one bit.
  localparam int            CW      = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

  logic [WIDTH-1:0][1:0]    cmd;
  logic [WIDTH-1:0][1:0]    cmd_prev;
  logic [WIDTH-1:0][1:0]    prev_nxt;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;
  logic [WIDTH-1:0]         qual;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         q_next;
  logic [WIDTH-1:0]         chg_r;
  logic                     conflict_r;
  logic                     conf_hit;

  // Per-channel filter tracking, qualification and next-state resolution.
  always_comb begin
    cmd      = '0;
    prev_nxt = cmd_prev;
    cnt_nxt  = cnt;
    qual     = '0;
    q_next   = q;
    conf_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i] = {bus.r[i], bus.s[i]};
      if (cmd[i] != cmd_prev[i]) begin
        prev_nxt[i] = cmd[i];
        cnt_nxt[i]  = '0;
      end else if (cnt[i] < CNT_MAX) begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
      // A command is applied on the edge its stability count reaches FILTER,
      // so with FILTER=0 every edge qualifies and the bank acts immediately.
      qual[i] = (cnt_nxt[i] == CNT_MAX);
      if (qual[i]) begin
        case (cmd[i])
          2'b01: q_next[i] = 1'b1;
          2'b10: q_next[i] = 1'b0;
          2'b11: begin
            conf_hit = 1'b1;
            if (CONFLICT_MODE == 0)      q_next[i] = 1'b0;
            else if (CONFLICT_MODE == 1) q_next[i] = 1'b1;
            else if (CONFLICT_MODE == 3) q_next[i] = ~q[i];
            else                         q_next[i] = q[i];
          end
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  // Filter state; reset discards any partial qualification progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_prev <= '0;
      cnt      <= '0;
    end else begin
      cmd_prev <= prev_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Channel state and per-channel change pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RESET_VAL;
      chg_r <= '0;
    end else begin
      q     <= q_next;
      chg_r <= q_next ^ q;
    end
  end

  // Sticky conflict flag; a new conflict beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= conf_hit | (conflict_r & ~bus.err_clr);
    end
  end

  assign bus.q        = q;
  assign bus.qb       = ~q;
  assign bus.changed  = chg_r;
  assign bus.conflict = conflict_r;
endmodule
